// File: rtl/lod_normalizer_pipe_pkg.sv
// Shared types and helpers for the leading-one normaliser pipeline.
// Optional build macro used by the block: LOD_NORM_ZERO_MODE_EN.
package lod_norm_pkg;

  // Cycles from input acceptance to the result appearing on the output
  localparam int LOD_NORM_LATENCY = 2;

  // Upper bounds that size the stage-1 payload struct
  localparam int LOD_NORM_MAX_W     = 64;
  localparam int LOD_NORM_MAX_POS_W = 6;
  localparam int LOD_NORM_MAX_TAG_W = 64;

  // Width needed to hold a bit index (and a shift amount) for a word of 'width' bits
  function automatic int lod_pos_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Stage-1 payload, sized for the largest legal configuration; narrower
  // instances use the low bits of each field and keep the rest at zero.
  typedef struct packed {
    logic [LOD_NORM_MAX_W-1:0]     data;
    logic [LOD_NORM_MAX_TAG_W-1:0] tag;
    logic [LOD_NORM_MAX_POS_W-1:0] pos;
    logic                          zero;
    logic                          mode;
  } lod_s1_t;

endpackage

// File: rtl/lod_normalizer_pipe_if.sv
// Handshake/data bundle for lod_normalizer_pipe.
// With LOD_NORM_ZERO_MODE_EN defined the bundle also carries in_mode/out_mode.
//
// Valid/ready contract (both sides): a word moves when valid && ready are both
// high at a rising clock edge; a source holding valid high keeps its payload
// stable until that edge, and ready may depend combinationally on the far side.
interface lod_normalizer_pipe_if
  import lod_norm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
);
  localparam int POS_W = lod_pos_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [POS_W-1:0] out_shift;
  logic [POS_W-1:0] out_pos;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

`ifdef LOD_NORM_ZERO_MODE_EN
  logic             in_mode;
  logic             out_mode;

  // Environment side: feeds words in and accepts results
  modport master (
    output in_valid, in_data, in_tag, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_pos, out_zero, out_tag, out_mode
  );

  // Block side
  modport slave (
    input  in_valid, in_data, in_tag, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_pos, out_zero, out_tag, out_mode
  );
`else
  // Environment side: feeds words in and accepts results
  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_pos, out_zero, out_tag
  );

  // Block side
  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_pos, out_zero, out_tag
  );
`endif

endinterface

// File: rtl/lod_normalizer_pipe_priority_tree.sv
// Combinational leading-one position finder built as a log2-depth tree.
// Each node merges two children: the higher child wins whenever it holds a
// set bit, otherwise the lower child's index is forwarded. An all-zero word
// falls through to index 0 with zero asserted.
module lod_priority_tree
  import lod_norm_pkg::*;
#(
  parameter  int WIDTH = 24,
  localparam int POS_W = lod_pos_w(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  // Leaves padded up to a power of two; padding leaves never hold a one
  localparam int LEAVES = 1 << POS_W;

  logic             lvl_v [POS_W+1][LEAVES];
  logic [POS_W-1:0] lvl_i [POS_W+1][LEAVES];

  // Build the leaf level, then merge pairs level by level up to the root
  always_comb begin
    for (int l = 0; l <= POS_W; l++) begin
      for (int n = 0; n < LEAVES; n++) begin
        lvl_v[l][n] = 1'b0;
        lvl_i[l][n] = '0;
      end
    end
    for (int n = 0; n < LEAVES; n++) begin
      lvl_i[0][n] = POS_W'(n);
    end
    for (int n = 0; n < WIDTH; n++) begin
      lvl_v[0][n] = data[n];
    end
    for (int l = 0; l < POS_W; l++) begin
      for (int n = 0; n < (LEAVES >> (l + 1)); n++) begin
        lvl_v[l+1][n] = lvl_v[l][2*n+1] | lvl_v[l][2*n];
        lvl_i[l+1][n] = lvl_v[l][2*n+1] ? lvl_i[l][2*n+1] : lvl_i[l][2*n];
      end
    end
  end

  assign pos  = lvl_i[POS_W][0];
  assign zero = ~lvl_v[POS_W][0];

endmodule

// File: rtl/lod_normalizer_pipe.sv
// Two-stage leading-one detector and left normaliser.
// Stage 1 registers the word with its leading-one position and zero flag;
// stage 2 registers the word shifted so that bit lands on the MSB.
// Build macro LOD_NORM_ZERO_MODE_EN adds in_mode/out_mode: with in_mode=1 the
// leading zero is located instead and vacated low bits fill with ones.
module lod_normalizer_pipe
  import lod_norm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  lod_normalizer_pipe_if.slave bus
);

  localparam int POS_W = lod_pos_w(WIDTH);

  if (WIDTH < 2 || WIDTH > LOD_NORM_MAX_W || TAG_W < 1 || TAG_W > LOD_NORM_MAX_TAG_W) begin : g_param_check
    $error("lod_normalizer_pipe: WIDTH must be 2..64 and TAG_W 1..64");
  end

  // Handshake: a stage advances when it is empty or the stage after it is
  // moving. in_ready is combinational from out_ready (no skid buffer), so a
  // stall only backs up to the input once stage 1 is also occupied.
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // ---------------------------------------------------------------- stage 1
  logic             in_mode_w;
  logic [WIDTH-1:0] det_src;
  logic [POS_W-1:0] det_pos;
  logic             det_zero;
  lod_s1_t          s1_d;
  lod_s1_t          s1_q;

`ifdef LOD_NORM_ZERO_MODE_EN
  assign in_mode_w = bus.in_mode;
`else
  assign in_mode_w = 1'b0;
`endif

  // Looking for the leading zero is the same search on the inverted word
  assign det_src = in_mode_w ? ~bus.in_data : bus.in_data;

  lod_priority_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .data (det_src),
    .pos  (det_pos),
    .zero (det_zero)
  );

  // Pack the accepted word and its detection result into the stage-1 payload
  always_comb begin
    s1_d                = '0;
    s1_d.data[WIDTH-1:0] = bus.in_data;
    s1_d.tag[TAG_W-1:0]  = bus.in_tag;
    s1_d.pos[POS_W-1:0]  = det_pos;
    s1_d.zero            = det_zero;
    s1_d.mode            = in_mode_w;
  end

  // Stage-1 register: load on advance, keep contents while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [WIDTH-1:0] s1_data;
  logic [TAG_W-1:0] s1_tag;
  logic [POS_W-1:0] s1_pos;
  logic             s1_zero;
  logic             s1_mode;
  logic [POS_W-1:0] shift_amt;
  logic [WIDTH-1:0] shifted;

  assign s1_data = s1_q.data[WIDTH-1:0];
  assign s1_tag  = s1_q.tag[TAG_W-1:0];
  assign s1_pos  = s1_q.pos[POS_W-1:0];
  assign s1_zero = s1_q.zero;
  assign s1_mode = s1_q.mode;

  // Unused upper payload bits of narrow configurations are gathered here
  logic unused_s1_bits;
  assign unused_s1_bits = ^s1_q;

  // Shift so the detected bit reaches the MSB; a word with nothing to find
  // is left unshifted. Leading-zero mode shifts in ones from the bottom.
  always_comb begin
    shift_amt = '0;
    shifted   = '0;
    if (!s1_zero) begin
      shift_amt = POS_W'(WIDTH - 1) - s1_pos;
    end
    if (s1_mode) begin
      shifted = ~((~s1_data) << shift_amt);
    end else begin
      shifted = s1_data << shift_amt;
    end
  end

  logic [WIDTH-1:0] out_data_q;
  logic [POS_W-1:0] out_shift_q;
  logic [POS_W-1:0] out_pos_q;
  logic             out_zero_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_mode_q;

  // Stage-2 register: output word holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_pos_q   <= '0;
      out_zero_q  <= 1'b0;
      out_tag_q   <= '0;
      out_mode_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data_q  <= shifted;
        out_shift_q <= shift_amt;
        out_pos_q   <= s1_pos;
        out_zero_q  <= s1_zero;
        out_tag_q   <= s1_tag;
        out_mode_q  <= s1_mode;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_pos   = out_pos_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_tag   = out_tag_q;

`ifdef LOD_NORM_ZERO_MODE_EN
  assign bus.out_mode = out_mode_q;
`else
  logic unused_mode;
  assign unused_mode = out_mode_q;
`endif

endmodule

// File: tb/tb_lod_normalizer_pipe.sv
// Self-checking bench for lod_normalizer_pipe (WIDTH=24, TAG_W=4).
// Define LOD_NORM_ZERO_MODE_EN to also exercise the leading-zero mode.
module tb_lod_normalizer_pipe;
  import lod_norm_pkg::*;

  localparam int W      = 24;
  localparam int TW     = 4;
  localparam int PW     = lod_pos_w(W);
  localparam int O_TAG   = 0;
  localparam int O_MODE  = TW;
  localparam int O_ZERO  = TW + 1;
  localparam int O_POS   = TW + 2;
  localparam int O_SHIFT = TW + 2 + PW;
  localparam int O_DATA  = TW + 2 + 2 * PW;
  localparam int EXP_W   = W + 2 * PW + 2 + TW;

  // ------------------------------------------------------ clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lod_normalizer_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  lod_normalizer_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic mode_drv;
  logic dut_mode;
`ifdef LOD_NORM_ZERO_MODE_EN
  assign bus.in_mode = mode_drv;
  assign dut_mode    = bus.out_mode;
`else
  assign dut_mode    = 1'b0;
`endif

  logic [EXP_W-1:0] dut_word;
  assign dut_word = {bus.out_data, bus.out_shift, bus.out_pos, bus.out_zero, dut_mode, bus.out_tag};

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // ------------------------------------------------------ reference model
  // Scan for the highest bit of interest, then multiply up to the MSB.
  function automatic logic [EXP_W-1:0] model(input logic [W-1:0] d, input logic [TW-1:0] t, input logic m);
    logic [W-1:0] probe;
    logic [W-1:0] o;
    logic         z;
    int           p;
    int           sh;
    probe = m ? ~d : d;
    z     = (probe == '0);
    p     = 0;
    for (int i = 0; i < W; i++) if (probe[i]) p = i;
    sh = z ? 0 : (W - 1 - p);
    o  = W'(d * (64'd1 << sh));
    if (m) o = o | W'((64'd1 << sh) - 64'd1);
    return {o, PW'(sh), PW'(p), z, m, t};
  endfunction

  function automatic logic [63:0] f_data (input logic [EXP_W-1:0] x); return 64'(x[O_DATA +: W]);   endfunction
  function automatic logic [63:0] f_shift(input logic [EXP_W-1:0] x); return 64'(x[O_SHIFT +: PW]); endfunction
  function automatic logic [63:0] f_pos  (input logic [EXP_W-1:0] x); return 64'(x[O_POS +: PW]);   endfunction
  function automatic logic [63:0] f_zero (input logic [EXP_W-1:0] x); return 64'(x[O_ZERO]);        endfunction
  function automatic logic [63:0] f_mode (input logic [EXP_W-1:0] x); return 64'(x[O_MODE]);        endfunction
  function automatic logic [63:0] f_tag  (input logic [EXP_W-1:0] x); return 64'(x[O_TAG +: TW]);   endfunction

  // ------------------------------------------------------ scoreboard
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] log_q[$];
  int               log_cyc[$];
  logic [EXP_W-1:0] last_word;
  logic [EXP_W-1:0] held_word;
  logic             stall_prev;
  logic             seen_ready_low;
  int               out_count = 0;
  int               cyc = 0;

  initial begin
    logic [EXP_W-1:0] mon_e;
    stall_prev     = 1'b0;
    seen_ready_low = 1'b0;
    held_word      = '0;
    last_word      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        check("in_ready_vs_occupancy", 64'(bus.in_ready),
              64'(!(exp_q.size() >= 2 && !bus.out_ready)));
        if (!bus.in_ready) seen_ready_low = 1'b1;
        if (exp_q.size() == 0) check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        if (stall_prev) begin
          check("stall_out_valid", 64'(bus.out_valid), 64'd1);
          check("stall_out_word", 64'(dut_word), 64'(held_word));
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held_word  = dut_word;
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out_data",  f_data(dut_word),  f_data(mon_e));
          check("out_shift", f_shift(dut_word), f_shift(mon_e));
          check("out_pos",   f_pos(dut_word),   f_pos(mon_e));
          check("out_zero",  f_zero(dut_word),  f_zero(mon_e));
          check("out_mode",  f_mode(dut_word),  f_mode(mon_e));
          check("out_tag",   f_tag(dut_word),   f_tag(mon_e));
          last_word = dut_word;
          log_q.push_back(dut_word);
          log_cyc.push_back(cyc);
          out_count++;
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data, bus.in_tag, mode_drv));
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t, input logic m);
    logic acc;
    int   guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_tag   = t;
    mode_drv     = m;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("send_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int target);
    int guard;
    guard = 0;
    while (out_count < target && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (out_count < target) check("wait_outputs_timeout", 64'(out_count), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ directed sequence
  initial begin
    logic [EXP_W-1:0] pin;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    mode_drv      = 1'b0;

    // Pin the model against hand-computed values
    pin = model(24'h000001, 4'h0, 1'b0);
    check("model_lsb_data", f_data(pin), 64'h800000);
    check("model_lsb_shift", f_shift(pin), 64'd23);
    pin = model(24'hFFFFFF, 4'h0, 1'b0);
    check("model_ones_pos", f_pos(pin), 64'd23);
    pin = model(24'h00F000, 4'h0, 1'b0);
    check("model_f000_data", f_data(pin), 64'hF00000);
    pin = model(24'hFFFF0F, 4'h0, 1'b1);
    check("model_zmode_data", f_data(pin), 64'h0FFFFF);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_shift", 64'(bus.out_shift), 64'd0);
    check("rst_out_pos",   64'(bus.out_pos),   64'd0);
    check("rst_out_zero",  64'(bus.out_zero),  64'd0);
    check("rst_out_tag",   64'(bus.out_tag),   64'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Single word through an idle pipe: latency and literal result
    send(24'h000001, 4'h1, 1'b0);
    idle();
    @(negedge clk);
    check("latency_early_valid", 64'(bus.out_valid), 64'd0);
    repeat (LOD_NORM_LATENCY - 1) @(negedge clk);
    check("latency_valid", 64'(bus.out_valid), 64'd1);
    check("lsb_out_data",  64'(bus.out_data),  64'h800000);
    check("lsb_out_shift", 64'(bus.out_shift), 64'd23);
    check("lsb_out_pos",   64'(bus.out_pos),   64'd0);
    check("lsb_out_zero",  64'(bus.out_zero),  64'd0);
    check("lsb_out_tag",   64'(bus.out_tag),   64'h1);
    @(posedge clk);
    #1;

    // All-zero input
    n = out_count;
    send(24'h000000, 4'h5, 1'b0);
    idle();
    wait_outs(n + 1);
    check("zero_flag",  f_zero(last_word),  64'd1);
    check("zero_data",  f_data(last_word),  64'd0);
    check("zero_shift", f_shift(last_word), 64'd0);
    check("zero_pos",   f_pos(last_word),   64'd0);
    check("zero_tag",   f_tag(last_word),   64'h5);

    // Back-to-back stream including the all-ones and MSB-set boundaries
    n = out_count;
    log_q.delete();
    log_cyc.delete();
    send(24'h800000, 4'h2, 1'b0);
    send(24'h400000, 4'h3, 1'b0);
    send(24'h00F000, 4'h4, 1'b0);
    send(24'hFFFFFF, 4'h6, 1'b0);
    send(24'hA5A5A5, 4'h7, 1'b0);
    idle();
    wait_outs(n + 5);
    if (log_q.size() >= 5) begin
      check("stream_shift0", f_shift(log_q[0]), 64'd0);
      check("stream_shift1", f_shift(log_q[1]), 64'd1);
      check("stream_shift2", f_shift(log_q[2]), 64'd8);
      check("stream_tag0",   f_tag(log_q[0]),   64'h2);
      check("stream_tag1",   f_tag(log_q[1]),   64'h3);
      check("stream_tag2",   f_tag(log_q[2]),   64'h4);
      check("ones_pos",      f_pos(log_q[3]),   64'd23);
      check("msb_data",      f_data(log_q[4]),  64'hA5A5A5);
      for (int i = 1; i < 5; i++) check("stream_consecutive", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end else begin
      check("stream_count", 64'(log_q.size()), 64'd5);
    end

    // Backpressure for four cycles while streaming
    n = out_count;
    log_q.delete();
    seen_ready_low = 1'b0;
    fork
      begin
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      begin
        send(24'h000013, 4'h8, 1'b0);
        send(24'h000200, 4'h9, 1'b0);
        send(24'h004321, 4'hA, 1'b0);
        send(24'h0A0000, 4'hB, 1'b0);
        idle();
      end
    join
    wait_outs(n + 4);
    repeat (5) @(posedge clk);
    #1;
    check("stall_out_count", 64'(out_count), 64'(n + 4));
    check("stall_ready_dropped", 64'(seen_ready_low), 64'd1);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("stall_tag_order", f_tag(log_q[i]), 64'(8 + i));
    end else begin
      check("stall_log_count", 64'(log_q.size()), 64'd4);
    end

    // Reset while two words are in flight
    bus.out_ready = 1'b0;
    send(24'h000111, 4'hC, 1'b0);
    send(24'h000222, 4'hD, 1'b0);
    idle();
    @(negedge clk);
    check("preflight_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_out_data",  64'(bus.out_data),  64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    n = out_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_quiet", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(24'h000300, 4'hE, 1'b0);
    idle();
    wait_outs(n + 1);
    check("post_reset_count", 64'(out_count), 64'(n + 1));
    check("post_reset_tag",   f_tag(last_word),   64'hE);
    check("post_reset_data",  f_data(last_word),  64'hC00000);
    check("post_reset_shift", f_shift(last_word), 64'd14);
    check("post_reset_pos",   f_pos(last_word),   64'd9);

`ifdef LOD_NORM_ZERO_MODE_EN
    // Leading-zero mode
    n = out_count;
    send(24'hFFFF0F, 4'hF, 1'b1);
    send(24'hFFFFFF, 4'h3, 1'b1);
    idle();
    wait_outs(n + 2);
    if (log_q.size() >= 2) begin
      check("zmode_pos",   f_pos(log_q[log_q.size()-2]),   64'd7);
      check("zmode_shift", f_shift(log_q[log_q.size()-2]), 64'd16);
      check("zmode_data",  f_data(log_q[log_q.size()-2]),  64'h0FFFFF);
      check("zmode_mode",  f_mode(log_q[log_q.size()-2]),  64'd1);
      check("zmode_ones_zero", f_zero(log_q[log_q.size()-1]), 64'd1);
    end
    mode_drv = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lod_normalizer_pipe.md
Name: lod_normalizer_pipe

Overview:
- Two-stage pipelined leading-one detector and left-normalizer for the parametrised floating-point datapath.
- Accepts a raw mantissa/significand with a valid/ready handshake.
- Returns the value shifted so its leading one sits at the MSB, plus shift amount, position and zero flag.
- Sits between the adder/multiplier result stage and the exponent-adjust/rounding stage; carries an opaque tag alongside.

Parameters:
- WIDTH, 24, input/output data width in bits; legal range 2..64.
- TAG_W, 4, sideband tag width; legal range >=1; carried unchanged.
- POS_W, $clog2(WIDTH), derived localparam; width of position and shift fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  value to normalise.
- in_tag  input  TAG_W  sideband, passed through.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  normalised value.
- out_shift  output  POS_W  left-shift amount applied (WIDTH-1-position).
- out_pos  output  POS_W  index of the highest set bit of in_data.
- out_zero  output  1  in_data was all zeros.
- out_tag  output  TAG_W  in_tag of this result.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_data, out_shift, out_pos and out_tag are 0.
  - out_zero=0.
  - in_ready=1 once reset is released.
- Stage 1 (detect):
  - Registers in_data, in_tag, the priority-encoded position and the zero flag.
  - Position = highest index i with in_data[i]=1; 0 when in_data=0.
- Stage 2 (shift):
  - Registers out_data = s1_data << (WIDTH-1-s1_pos).
  - Registers out_shift = WIDTH-1-s1_pos, and passes pos, zero and tag through.
  - Zero input: out_data=0, out_shift=0, out_pos=0, out_zero=1.
- Latency:
  - Exactly 2 cycles from input acceptance to out_valid when there is no backpressure.
  - Full throughput of 1 word/cycle.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
  - When stalled (out_valid && !out_ready), out_* and s1 contents hold stable; in_ready=0 only if s1 is also full.
  - Simultaneous input transfer and output transfer in the same cycle: both occur and nothing is lost.
  - in_valid deasserted: bubbles propagate, and the valid bits clear as the data drains.
- Arithmetic: shift amount is always <= WIDTH-1; no bits are lost; MSB of out_data is 1 unless out_zero.
- Boundaries:
  - in_data = 1 gives shift WIDTH-1.
  - in_data MSB set gives shift 0 and out_data = in_data.
  - All-ones input gives pos WIDTH-1.
- Reset mid-operation: all in-flight words are discarded immediately; no spurious out_valid after reset release.
- Data registers are not required to be reset for correctness, but are reset to 0 for deterministic verification.

Optional Feature:
- Macro: LOD_NORM_ZERO_MODE_EN.
- Defined:
  - Adds input port in_mode (1 bit), sampled with in_data and pipelined.
  - in_mode=0: leading-one detection as above.
  - in_mode=1: detect the leading zero. Position = highest 0 bit. Normalise by shifting left so that bit reaches the MSB; vacated LSBs fill with 1s. out_zero means in_data was all ones.
  - Adds output port out_mode, which carries in_mode through.
- Undefined: the in_mode and out_mode ports do not exist; behaviour is leading-one only.

Decomposition:
- Package lod_norm_pkg holds:
  - a function computing the position-width from WIDTH;
  - a typedef for the stage-1 payload struct (data, tag, pos, zero, mode);
  - a localparam LOD_NORM_LATENCY=2.
- One combinational sub-module lod_priority_tree:
  - parametrised WIDTH;
  - outputs pos and zero;
  - implemented as a log2-depth tree of pairwise valid/index merges, not a linear scan;
  - instantiated in stage 1.

Test Plan:
- WIDTH=24, in_data=0x000001, out_ready=1 -> 2 cycles later: out_data=0x800000, out_shift=23, out_pos=0, out_zero=0.
- in_data=0x000000, tag=0x5 -> out_zero=1, out_data=0, out_shift=0, out_pos=0, out_tag=0x5.
- Stream 0x800000, 0x400000, 0x00F000 on back-to-back cycles -> outputs arrive on consecutive cycles with shifts 0, 1, 8 and tags preserved in order.
- Streaming with out_ready held low 3 cycles -> out_* stable throughout; in_ready drops after s1 fills; on release, no word is dropped or duplicated.
- Assert rst_n low while 2 words are in flight -> out_valid=0 asynchronously; after release, the first out_valid corresponds only to new inputs.
- LOD_NORM_ZERO_MODE_EN, in_mode=1, in_data=0xFFFF0F -> pos=7, out_shift=16, out_data=0x0FFFFF.
